conv_out_requant_axis: RTL

//  Downstream stage of the conv PE: takes 48-bit accumulated results (PE BRAM_doutb + valid/last).

---
 rtl/conv_out_requant_axis.sv | 128 ++++++++++++
 1 files changed

// File: rtl/conv_out_requant_axis.sv
// Requantisation tail of the conv PE: activation, round-shift, saturation,
// then a small FWFT FIFO feeding an AXI4-Stream master with tready backpressure.
module conv_out_requant_axis #(
  parameter int RESULT_WIDTH = 48,
  parameter int OUT_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                           clk,
  input  logic                           Reset_n,
  input  logic signed [RESULT_WIDTH-1:0] s_data,
  input  logic                           s_valid,
  input  logic                           s_last,
  output logic                           s_afull,
  input  logic [5:0]                     cfg_shift,
  input  logic [1:0]                     cfg_act,
  output logic signed [OUT_WIDTH-1:0]    m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           overflow_err,
  output logic [15:0]                    sat_count
);

  localparam int EW = RESULT_WIDTH + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] ACT_RELU  = 2'd1;
  localparam logic [1:0] ACT_LEAKY = 2'd2;

  logic                           s1_valid, s1_last;
  logic signed [RESULT_WIDTH-1:0] s1_data;
  logic                           s2_valid, s2_last;
  logic signed [OUT_WIDTH-1:0]    s2_data;

  logic signed [RESULT_WIDTH-1:0] act_data;
  logic signed [EW-1:0]           ext_data, rnd_data, shifted;
  logic [EW-1:0]                  round_bias;
  logic [EW-OUT_WIDTH:0]          top_bits;
  logic                           clamp;
  logic signed [OUT_WIDTH-1:0]    sat_data;

  logic [OUT_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic               full, pop, push;
  logic [AW+1:0]      occ;

  always_comb begin
    act_data = s_data;
    if (s_data[RESULT_WIDTH-1]) begin
      if (cfg_act == ACT_RELU)       act_data = '0;
      else if (cfg_act == ACT_LEAKY) act_data = s_data >>> 3;
    end
  end

  // One extra bit of headroom so adding the half-LSB bias can never wrap.
  always_comb begin
    ext_data   = {s1_data[RESULT_WIDTH-1], s1_data};
    round_bias = ({{(EW-1){1'b0}}, 1'b1} << cfg_shift) >> 1;
    rnd_data   = ext_data + $signed(round_bias);
    shifted    = rnd_data >>> cfg_shift;
    top_bits   = shifted[EW-1:OUT_WIDTH-1];
    clamp      = !((&top_bits) || (~|top_bits));
    sat_data   = shifted[OUT_WIDTH-1:0];
    if (clamp)
      sat_data = shifted[EW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                               : {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= s_valid;
      s1_last  <= s_last;
      s1_data  <= act_data;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_data   <= '0;
      sat_count <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_data  <= sat_data;
      if (s1_valid && clamp && sat_count != 16'hFFFF)
        sat_count <= sat_count + 16'd1;
    end
  end

  // At full, a push is only accepted when the head leaves in the same cycle.
  always_comb begin
    full          = (count == (AW+1)'(FIFO_DEPTH));
    m_axis_tvalid = (count != '0);
    {m_axis_tlast, m_axis_tdata} = mem[rd_ptr];
    pop           = m_axis_tvalid && m_axis_tready;
    push          = s2_valid && (!full || pop);
    occ           = (AW+2)'(count) + (AW+2)'(s1_valid) + (AW+2)'(s2_valid);
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
      s_afull      <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {s2_last, s2_data};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (!push && pop) count <= count - (AW+1)'(1);
      if (s2_valid && full && !pop) overflow_err <= 1'b1;
      s_afull <= (occ >= (AW+2)'(FIFO_DEPTH - AFULL_MARGIN));
    end
  end

endmodule
